// File: rtl/mips_id_pkg.sv
// Shared constants for the MIPS decode stage: opcodes, functs, control-bit
// positions within the WB/MEM/EX bundles and the bubble value.
package mips_id_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_ORI   = 6'b001101,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL = 6'b000000,
        FN_SRL = 6'b000010,
        FN_SRA = 6'b000011
    } funct_e;

    localparam int CTRL_WB_W  = 2;
    localparam int CTRL_MEM_W = 3;
    localparam int CTRL_EX_W  = 7;

    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;

    localparam int MEM_MEMREAD  = 2;
    localparam int MEM_MEMWRITE = 1;
    localparam int MEM_BRANCH   = 0;

    localparam int EX_REGDST    = 6;
    localparam int EX_ALUSRC    = 5;
    localparam int EX_ALUOP_HI  = 4;
    localparam int EX_ALUOP_LO  = 3;
    localparam int EX_ZEROEXT   = 2;
    localparam int EX_SHAMTSEL  = 1;

    typedef struct packed {
        logic [CTRL_WB_W-1:0]  wb;
        logic [CTRL_MEM_W-1:0] mem;
        logic [CTRL_EX_W-1:0]  ex;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/banco_registros.sv
// Register bank: two read ports plus a debug port, one write port,
// same-cycle write bypass on every read, register 0 hardwired to zero.
module banco_registros #(
    parameter int len                  = 32,
    parameter int cantidad_registros   = 32,
    parameter int NB_address_registros = $clog2(cantidad_registros)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NB_address_registros-1:0] i_read_reg1,
    input  logic [NB_address_registros-1:0] i_read_reg2,
    input  logic [NB_address_registros-1:0] i_debug_addr,
    input  logic [NB_address_registros-1:0] i_write_reg,
    input  logic [len-1:0]                  i_write_data,
    input  logic                            i_RegWrite,
    output logic [len-1:0]                  o_dato1,
    output logic [len-1:0]                  o_dato2,
    output logic [len-1:0]                  o_debug_data
);

    logic [len-1:0] regs [cantidad_registros];
    logic           wr_active;

    assign wr_active = i_RegWrite && (i_write_reg != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int unsigned i = 0; i < cantidad_registros; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[i_write_reg] <= i_write_data;
        end
    end

    // Bypass lets a read in the write cycle see the value being written.
    assign o_dato1 = (i_read_reg1 == '0) ? '0 :
                     (wr_active && i_write_reg == i_read_reg1) ? i_write_data : regs[i_read_reg1];
    assign o_dato2 = (i_read_reg2 == '0) ? '0 :
                     (wr_active && i_write_reg == i_read_reg2) ? i_write_data : regs[i_read_reg2];
    assign o_debug_data = (i_debug_addr == '0) ? '0 :
                     (wr_active && i_write_reg == i_debug_addr) ? i_write_data : regs[i_debug_addr];

endmodule

// File: rtl/tl_instruction_decode_pipe.sv
// Pipelined MIPS decode stage: control decode, immediate extension,
// load-use hazard detection and the ID/EX pipeline register.
module tl_instruction_decode_pipe
    import mips_id_pkg::*;
#(
    parameter int len                  = 32,
    parameter int cantidad_registros   = 32,
    parameter int NB_address_registros = $clog2(cantidad_registros),
    parameter int NB_sign_extend       = 16,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 3,
    parameter int NB_CTRL_EX           = 7
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [len-1:0]                  i_instruccion,
    input  logic [len-1:0]                  i_adder_pc,
    input  logic [len-1:0]                  i_write_data,
    input  logic [NB_address_registros-1:0] i_write_reg,
    input  logic                            i_RegWrite,
    input  logic                            i_flush,
    input  logic [NB_address_registros-1:0] i_debug_addr,
    output logic [len-1:0]                  o_debug_data,
    output logic                            o_stall,
    output logic [len-1:0]                  o_adder_pc,
    output logic [len-1:0]                  o_dato1,
    output logic [len-1:0]                  o_dato2,
    output logic [len-1:0]                  o_sign_extend,
    output logic [NB_address_registros-1:0] o_rs,
    output logic [NB_address_registros-1:0] o_rt,
    output logic [NB_address_registros-1:0] o_rd,
    output logic [NB_address_registros-1:0] o_shamt,
    output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
    output logic [NB_CTRL_MEM-1:0]          o_ctrl_mem,
    output logic [NB_CTRL_EX-1:0]           o_ctrl_ex
);

    logic [5:0]                      opcode;
    logic [5:0]                      funct;
    logic [NB_address_registros-1:0] rs, rt, rd, shamt;
    logic [NB_sign_extend-1:0]       imm;
    logic [len-1:0]                  dato1, dato2, imm_ext;
    ctrl_t                           ctrl_dec, ctrl_next;
    logic                            hazard, bubble;

    assign opcode = i_instruccion[31:26];
    assign funct  = i_instruccion[5:0];
    assign rs     = i_instruccion[25:21];
    assign rt     = i_instruccion[20:16];
    assign rd     = i_instruccion[15:11];
    assign shamt  = i_instruccion[10:6];
    assign imm    = i_instruccion[NB_sign_extend-1:0];

    banco_registros #(
        .len                  (len),
        .cantidad_registros   (cantidad_registros),
        .NB_address_registros (NB_address_registros)
    ) u_banco (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_read_reg1  (rs),
        .i_read_reg2  (rt),
        .i_debug_addr (i_debug_addr),
        .i_write_reg  (i_write_reg),
        .i_write_data (i_write_data),
        .i_RegWrite   (i_RegWrite),
        .o_dato1      (dato1),
        .o_dato2      (dato2),
        .o_debug_data (o_debug_data)
    );

    always_comb begin
        ctrl_dec = CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                ctrl_dec.wb[WB_REGWRITE]  = 1'b1;
                ctrl_dec.ex[EX_REGDST]    = 1'b1;
                ctrl_dec.ex[EX_ALUOP_HI]  = 1'b1;
                if (funct inside {FN_SLL, FN_SRL, FN_SRA}) begin
                    ctrl_dec.ex[EX_SHAMTSEL] = 1'b1;
                end
            end
            OP_LW: begin
                ctrl_dec.wb[WB_REGWRITE]  = 1'b1;
                ctrl_dec.wb[WB_MEMTOREG]  = 1'b1;
                ctrl_dec.mem[MEM_MEMREAD] = 1'b1;
                ctrl_dec.ex[EX_ALUSRC]    = 1'b1;
            end
            OP_SW: begin
                ctrl_dec.mem[MEM_MEMWRITE] = 1'b1;
                ctrl_dec.ex[EX_ALUSRC]     = 1'b1;
            end
            OP_BEQ: begin
                ctrl_dec.mem[MEM_BRANCH]  = 1'b1;
                ctrl_dec.ex[EX_ALUOP_LO]  = 1'b1;
            end
            OP_ADDI: begin
                ctrl_dec.wb[WB_REGWRITE]  = 1'b1;
                ctrl_dec.ex[EX_ALUSRC]    = 1'b1;
                ctrl_dec.ex[EX_ALUOP_HI]  = 1'b1;
                ctrl_dec.ex[EX_ALUOP_LO]  = 1'b1;
            end
            OP_ORI: begin
                ctrl_dec.wb[WB_REGWRITE]  = 1'b1;
                ctrl_dec.ex[EX_ALUSRC]    = 1'b1;
                ctrl_dec.ex[EX_ALUOP_HI]  = 1'b1;
                ctrl_dec.ex[EX_ALUOP_LO]  = 1'b1;
                ctrl_dec.ex[EX_ZEROEXT]   = 1'b1;
            end
            default: ctrl_dec = CTRL_BUBBLE;
        endcase
    end

    assign imm_ext = ctrl_dec.ex[EX_ZEROEXT]
                   ? {{(len-NB_sign_extend){1'b0}}, imm}
                   : {{(len-NB_sign_extend){imm[NB_sign_extend-1]}}, imm};

    // Load in EX whose destination feeds this instruction; flush masks the stall.
    assign hazard    = o_ctrl_mem[MEM_MEMREAD] && (o_rt != '0) && ((o_rt == rs) || (o_rt == rt));
    assign o_stall   = hazard && !i_flush;
    assign bubble    = hazard || i_flush;
    assign ctrl_next = bubble ? CTRL_BUBBLE : ctrl_dec;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_adder_pc    <= '0;
            o_dato1       <= '0;
            o_dato2       <= '0;
            o_sign_extend <= '0;
            o_rs          <= '0;
            o_rt          <= '0;
            o_rd          <= '0;
            o_shamt       <= '0;
            o_ctrl_wb     <= '0;
            o_ctrl_mem    <= '0;
            o_ctrl_ex     <= '0;
        end else begin
            o_adder_pc    <= i_adder_pc;
            o_dato1       <= dato1;
            o_dato2       <= dato2;
            o_sign_extend <= imm_ext;
            o_rs          <= rs;
            o_rt          <= rt;
            o_rd          <= rd;
            o_shamt       <= shamt;
            o_ctrl_wb     <= ctrl_next.wb;
            o_ctrl_mem    <= ctrl_next.mem;
            o_ctrl_ex     <= ctrl_next.ex;
        end
    end

endmodule

// File: tb/tb_tl_instruction_decode_pipe.sv
// Self-checking bench for tl_instruction_decode_pipe: directed scenarios then
// randomized traffic, all checked against a behavioural model of the stage.
module tb_tl_instruction_decode_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] instr, pc, wdata;
    logic [4:0]  wreg, dbg;
    logic        wen, flush;
    logic [31:0] debug_data, o_pc, o_d1, o_d2, o_se;
    logic        stall;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [1:0]  o_wb;
    logic [2:0]  o_mem;
    logic [6:0]  o_ex;

    int checks = 0;
    int errors = 0;

    tl_instruction_decode_pipe #(
        .len                (32),
        .cantidad_registros (32)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instruccion (instr),
        .i_adder_pc    (pc),
        .i_write_data  (wdata),
        .i_write_reg   (wreg),
        .i_RegWrite    (wen),
        .i_flush       (flush),
        .i_debug_addr  (dbg),
        .o_debug_data  (debug_data),
        .o_stall       (stall),
        .o_adder_pc    (o_pc),
        .o_dato1       (o_d1),
        .o_dato2       (o_d2),
        .o_sign_extend (o_se),
        .o_rs          (o_rs),
        .o_rt          (o_rt),
        .o_rd          (o_rd),
        .o_shamt       (o_shamt),
        .o_ctrl_wb     (o_wb),
        .o_ctrl_mem    (o_mem),
        .o_ctrl_ex     (o_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] e_pc, e_d1, e_d2, e_se;
    logic [4:0]  e_rs, e_rt, e_rd, e_shamt;
    logic [11:0] e_ctrl;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {wb[1:0], mem[2:0], ex[6:0]} straight from the opcode table
    function automatic logic [11:0] ref_ctrl(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'b000000: ref_ctrl = (fn == 6'd0 || fn == 6'd2 || fn == 6'd3)
                                  ? {2'b10, 3'b000, 7'b1010010}
                                  : {2'b10, 3'b000, 7'b1010000};
            6'b100011: ref_ctrl = {2'b11, 3'b100, 7'b0100000};
            6'b101011: ref_ctrl = {2'b00, 3'b010, 7'b0100000};
            6'b000100: ref_ctrl = {2'b00, 3'b001, 7'b0001000};
            6'b001000: ref_ctrl = {2'b10, 3'b000, 7'b0111000};
            6'b001101: ref_ctrl = {2'b10, 3'b000, 7'b0111100};
            default:   ref_ctrl = 12'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0)                   ref_read = 32'd0;
        else if (wen && wreg == a)       ref_read = wdata;
        else                             ref_read = m_regs[a];
    endfunction

    task automatic cycle(input logic [31:0] ins, input logic [31:0] wd, input logic [4:0] wr,
                         input logic we, input logic fl, input logic r);
        logic [4:0]  s, t;
        logic [11:0] c;
        logic        hz;
        logic [31:0] ext;
        @(negedge clk);
        instr = ins; pc = $urandom; wdata = wd; wreg = wr; wen = we;
        flush = fl; rst = r; dbg = 5'($urandom_range(0, 31));
        #1;
        s  = ins[25:21];
        t  = ins[20:16];
        hz = e_ctrl[9] && (e_rt != 5'd0) && (e_rt == s || e_rt == t);
        last_stall = stall;
        chk("stall", {31'd0, stall}, {31'd0, hz && !fl});
        chk("debug_data", debug_data, ref_read(dbg));
        c   = ref_ctrl(ins);
        ext = c[2] ? {16'd0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        if (!r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            e_pc = 0; e_d1 = 0; e_d2 = 0; e_se = 0;
            e_rs = 0; e_rt = 0; e_rd = 0; e_shamt = 0; e_ctrl = 0;
        end else begin
            e_pc = pc; e_d1 = ref_read(s); e_d2 = ref_read(t); e_se = ext;
            e_rs = s; e_rt = t; e_rd = ins[15:11]; e_shamt = ins[10:6];
            e_ctrl = (hz || fl) ? 12'd0 : c;
            if (we && wr != 5'd0) m_regs[wr] = wd;
        end
        @(posedge clk);
        #1;
        chk("adder_pc", o_pc, e_pc);
        chk("dato1", o_d1, e_d1);
        chk("dato2", o_d2, e_d2);
        chk("sign_extend", o_se, e_se);
        chk("rs", {27'd0, o_rs}, {27'd0, e_rs});
        chk("rt", {27'd0, o_rt}, {27'd0, e_rt});
        chk("rd", {27'd0, o_rd}, {27'd0, e_rd});
        chk("shamt", {27'd0, o_shamt}, {27'd0, e_shamt});
        chk("ctrl", {20'd0, o_wb, o_mem, o_ex}, {20'd0, e_ctrl});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op, fn;
        logic [4:0] s, t;
        s = 5'($urandom_range(0, 3));
        t = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
            0, 1:    op = 6'b000000;
            2, 3:    op = 6'b100011;
            4:       op = 6'b101011;
            5:       op = 6'b000100;
            6:       op = ($urandom_range(0, 1) != 0) ? 6'b001000 : 6'b001101;
            default: op = 6'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0:       fn = 6'd0;
            1:       fn = 6'd2;
            2:       fn = 6'd3;
            default: fn = 6'($urandom);
        endcase
        rand_instr = {op, s, t, 16'($urandom)};
        if (op == 6'b000000) rand_instr[5:0] = fn;
    endfunction

    initial begin
        rst = 1'b0; instr = '0; pc = '0; wdata = '0; wreg = '0;
        wen = 1'b0; flush = 1'b0; dbg = '0; last_stall = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        e_pc = 0; e_d1 = 0; e_d2 = 0; e_se = 0;
        e_rs = 0; e_rt = 0; e_rd = 0; e_shamt = 0; e_ctrl = 0;
        #1;
        chk("reset_ctrl", {20'd0, o_wb, o_mem, o_ex}, 32'd0);
        chk("reset_dato1", o_d1, 32'd0);

        // R-type add
        cycle(32'h0, 32'd5, 5'd1, 1'b1, 1'b0, 1'b1);
        cycle(32'h0, 32'd7, 5'd2, 1'b1, 1'b0, 1'b1);
        cycle(32'h00221820, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("tp1_dato1", o_d1, 32'd5);
        chk("tp1_dato2", o_d2, 32'd7);
        chk("tp1_rd", {27'd0, o_rd}, 32'd3);
        chk("tp1_ctrl", {20'd0, o_wb, o_mem, o_ex}, {20'd0, 2'b10, 3'b000, 7'b1010000});

        // lw sign extension, then ori zero extension
        cycle(32'h8C228020, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("tp2_lw_se", o_se, 32'hFFFF8020);
        chk("tp2_lw_ctrl", {20'd0, o_wb, o_mem, o_ex}, {20'd0, 2'b11, 3'b100, 7'b0100000});
        cycle(32'h0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        cycle(32'h3422FFFF, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("tp2_ori_se", o_se, 32'h0000FFFF);
        chk("tp2_ori_ex", {25'd0, o_ex}, {25'd0, 7'b0111100});

        // Load-use: one stall cycle, bubble, then the held add issues
        cycle(32'h8C220000, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        cycle(32'h00411820, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("tp3_stall", {31'd0, last_stall}, 32'd1);
        chk("tp3_bubble", {20'd0, o_wb, o_mem, o_ex}, 32'd0);
        cycle(32'h00411820, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("tp3_nostall", {31'd0, last_stall}, 32'd0);
        chk("tp3_issue", {20'd0, o_wb, o_mem, o_ex}, {20'd0, 2'b10, 3'b000, 7'b1010000});

        // Bypass and register 0
        cycle(32'h00201820, 32'hA5, 5'd1, 1'b1, 1'b0, 1'b1);
        chk("tp4_bypass", o_d1, 32'hA5);
        cycle(32'h0, 32'h1234, 5'd0, 1'b1, 1'b0, 1'b1);
        cycle(32'h00001820, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("tp4_reg0", o_d1, 32'd0);

        // Flush wins over a same-cycle stall
        cycle(32'h8C220000, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        cycle(32'h00411820, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("tp5_stall", {31'd0, last_stall}, 32'd0);
        chk("tp5_ctrl", {20'd0, o_wb, o_mem, o_ex}, 32'd0);

        // Reset mid-stream clears the bank
        cycle(32'h0, 32'd5, 5'd1, 1'b1, 1'b0, 1'b1);
        cycle(32'h8C220000, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("tp6_ctrl", {20'd0, o_wb, o_mem, o_ex}, 32'd0);
        cycle(32'h00201820, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("tp6_r1", o_d1, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(rand_instr(), $urandom, 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 63) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_instruction_decode_pipe.md
# tl_instruction_decode_pipe

Pipelined MIPS instruction-decode stage: register bank, main control decoder, sign/zero extension, load-use hazard detection and the ID/EX pipeline register, all in one block. It sits between the IF/ID register and the execute stage. Compared with the single-cycle decode it adds four things: a registered ID/EX output, a same-cycle write bypass, a bubble/stall mechanism, and a debug read port.

## Interface
- len, 32, data/instruction width
- cantidad_registros, 32, register-bank depth
- NB_address_registros, $clog2(cantidad_registros), register address width
- NB_sign_extend, 16, immediate field width
- NB_CTRL_WB, 2, WB control width {RegWrite, MemtoReg}
- NB_CTRL_MEM, 3, MEM control width {MemRead, MemWrite, Branch}
- NB_CTRL_EX, 7, EX control width {RegDst, ALUSrc, ALUOp[1:0], ZeroExt, ShamtSel, 0}

Ports:
- i_clk  in  1  single clock; all state on rising edge
- i_rst  in  1  synchronous, active-low reset
- i_instruccion  in  len  instruction from IF/ID
- i_adder_pc  in  len  PC+4 from IF/ID
- i_write_data  in  len  WB write data
- i_write_reg  in  NB_address_registros  WB destination
- i_RegWrite  in  1  WB write enable
- i_flush  in  1  turn this cycle's instruction into a bubble
- i_debug_addr  in  NB_address_registros  debug read address
- o_debug_data  out  len  combinational register read for the debug unit
- o_stall  out  1  combinational; hold PC and IF/ID
- o_adder_pc, o_dato1, o_dato2, o_sign_extend  out  len  registered ID/EX outputs
- o_rs, o_rt, o_rd, o_shamt  out  NB_address_registros  registered instruction fields
- o_ctrl_wb / o_ctrl_mem / o_ctrl_ex  out  NB_CTRL_WB / NB_CTRL_MEM / NB_CTRL_EX  registered control

## Operation
**Field extraction**
- rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], imm=[15:0].

**Control decoder**
- R-type (op 000000): wb=10, mem=000, ex=1010000.
  - funct sll/srl/sra (000000/000010/000011) also sets ShamtSel.
- lw (100011): wb=11, mem=100, ex=0100000.
- sw (101011): wb=00, mem=010, ex=0100000.
- beq (000100): wb=00, mem=001, ex=0001000.
- addi (001000): wb=10, mem=000, ex=0111000.
- ori (001101): wb=10, mem=000, ex=0111100.
- Any other opcode: all controls zero.

**Immediate**
- o_sign_extend is imm sign-extended to len.
- When ZeroExt=1 it is zero-extended instead.

**Register bank**
- Register 0 always reads 0; writes to it are ignored.
- Writes happen on the clock edge when i_RegWrite=1.
- Read bypass: if i_RegWrite=1 and i_write_reg equals a nonzero read address, that read returns i_write_data in the same cycle.
- The debug port uses the same bypass rule.

**Hazard detection**
- o_stall=1 when all of the following hold:
  - registered o_ctrl_mem[MemRead]=1;
  - o_rt≠0;
  - o_rt equals the current rs, or o_rt equals the current rt.
- While stalled, the ID/EX register loads zero controls (bubble). Data and field outputs still load normally.

**Flush**
- i_flush=1 loads a bubble and forces o_stall=0.
- Flush therefore overrides a stall raised in the same cycle.

## Timing
- Reset (i_rst=0 at an edge): every registered output and every bank entry becomes 0. A reset asserted mid-operation discards any pending instruction.
- ID/EX latency is 1 cycle: inputs present at edge N appear on the outputs after edge N.
- o_stall and o_debug_data are combinational and have zero latency.
- A load-use pair stalls for exactly one cycle. After the bubble, o_ctrl_mem[MemRead]=0, so o_stall drops and the held instruction issues.
- A bank write and a registered read of the same address at the same edge: the ID/EX register captures the new data, via the bypass.

## Structure
- Package mips_id_pkg holds:
  - opcode and funct constants;
  - control bit-position constants for the WB, MEM and EX fields;
  - bubble constant (all zeros).
- Sub-module banco_registros: parametrised depth/width, two read ports plus the debug port, one write port, write bypass, and register 0 hardwired to zero.
- Decoder, extension logic, hazard detection and the ID/EX register live in the top level.

## Test plan
1. **R-type add.** Bank writes r1=5, r2=7, then instr 0x00221820 (add $3,$1,$2). Expected after one edge: dato1=5, dato2=7, rd=3, wb=10, mem=000, ex=1010000.
2. **lw immediate.** instr 0x8C228020 (lw $2,0x8020($1)). Expected: sign_extend=0xFFFF8020, wb=11, mem=100, ex=0100000. Then ori 0x3422FFFF. Expected: sign_extend=0x0000FFFF, ex=0111100.
3. **Load-use stall.** lw $2 followed by add $3,$2,$1. Expected: o_stall=1 for one cycle; next outputs wb/mem/ex=0; following edge issues the add with its normal controls.
4. **Bypass and register 0.** i_RegWrite=1, i_write_reg=1, i_write_data=0xA5, in the same cycle as an instr reading $1. Expected: dato1=0xA5. Separately, write 0x1234 to reg 0, then read it. Expected: 0.
5. **Flush over stall.** Load-use condition together with i_flush=1. Expected: o_stall=0 and registered controls zero.
6. **Reset mid-stream.** Drop i_rst after loading r1=5. Expected: all outputs 0 and a later read of r1 returns 0.
